// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ILEN          : instruction / address width
//   NOP_INST      : instruction word presented to decode as a bubble
//   fetch_state_e : fetch FSM state encoding
package fetch_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry skid register holding an instruction word and its PC.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : capture {i_inst, i_pc} and mark the entry valid
//   i_clear        : invalidate the entry (wins over i_load)
//   o_valid        : entry holds a live instruction
//   o_inst, o_pc   : stored instruction word and PC
module fetch_skid_reg
  import fetch_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [ILEN-1:0] i_inst,
  input  logic [ILEN-1:0] i_pc,
  output logic            o_valid,
  output logic [ILEN-1:0] o_inst,
  output logic [ILEN-1:0] o_pc
);

  logic                valid_q;
  logic [2*ILEN-1:0]   data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (i_clear) begin
      valid_q <= 1'b0;
    end else if (i_load) begin
      valid_q <= 1'b1;
      data_q  <= {i_inst, i_pc};
    end
  end

  assign o_valid = valid_q;
  assign o_inst  = data_q[2*ILEN-1:ILEN];
  assign o_pc    = data_q[ILEN-1:0];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: issues one I-cache read per PC, advances the PC
// register on acceptance and fills the IF/ID pipeline register. A one-entry
// skid buffer absorbs a response that lands while decode is stalled.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_pc                  : current PC from the PC register
//   i_flush               : redirect; drops in-flight read, bubbles IF/ID
//   i_id_stall            : decode cannot accept a new instruction
//   o_if_en               : PC register advance enable
//   o_imem_req/o_imem_addr: I-cache read request and address
//   i_imem_ready          : cache accepts the request
//   i_imem_valid/rdata    : read response (one pulse per accepted request)
//   o_id_valid/inst/pc    : IF/ID register contents
//   o_id_inc_pc           : o_id_pc + 4
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] NOP_INST = fetch_pkg::NOP_INST
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [ILEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_id_stall,
  output logic            o_if_en,
  output logic            o_imem_req,
  output logic [ILEN-1:0] o_imem_addr,
  input  logic            i_imem_ready,
  input  logic            i_imem_valid,
  input  logic [ILEN-1:0] i_imem_rdata,
  output logic            o_id_valid,
  output logic [ILEN-1:0] o_id_inst,
  output logic [ILEN-1:0] o_id_pc,
  output logic [ILEN-1:0] o_id_inc_pc
);

  fetch_state_e    state_q, state_d;
  logic [ILEN-1:0] req_pc_q, req_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [ILEN-1:0] id_inst_q, id_inst_d;
  logic [ILEN-1:0] id_pc_q, id_pc_d;

  logic            skid_load, skid_clear, skid_valid;
  logic [ILEN-1:0] skid_inst, skid_pc;
  logic            id_can_load, rsp_now, skid_move;

  // Gating with i_rst_n keeps the request low throughout reset, and gating
  // with i_flush stops a stale address being accepted on the redirect edge.
  assign o_imem_req  = (state_q == S_REQ) & ~i_flush & i_rst_n;
  assign o_if_en     = o_imem_req & i_imem_ready;
  assign o_imem_addr = i_pc;

  assign id_can_load = ~id_valid_q | ~i_id_stall;
  assign rsp_now     = (state_q == S_WAIT) & i_imem_valid;
  assign skid_move   = (state_q == S_HOLD) & ~i_id_stall & skid_valid;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    if (i_flush) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
      skid_clear = 1'b1;
      unique case (state_q)
        S_REQ:   state_d = S_REQ;
        S_HOLD:  state_d = S_REQ;
        // A response landing on the flush cycle is simply dropped; otherwise
        // the stale one is still owed and must be swallowed in S_DRAIN.
        S_WAIT:  state_d = i_imem_valid ? S_REQ : S_DRAIN;
        S_DRAIN: state_d = i_imem_valid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (o_if_en) begin
        req_pc_d = i_pc;
      end

      unique case (state_q)
        S_REQ: begin
          if (o_if_en) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (i_imem_valid) begin
            if (id_can_load) begin
              state_d = S_REQ;
            end else begin
              skid_load = 1'b1;
              state_d   = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (skid_move) begin
            skid_clear = 1'b1;
            state_d    = S_REQ;
          end
        end
        S_DRAIN: begin
          if (i_imem_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase

      // IF/ID: skid has priority (it is older), then a fresh response,
      // otherwise a bubble whenever decode is able to take something.
      if (skid_move) begin
        id_valid_d = 1'b1;
        id_inst_d  = skid_inst;
        id_pc_d    = skid_pc;
      end else if (id_can_load) begin
        if (rsp_now) begin
          id_valid_d = 1'b1;
          id_inst_d  = i_imem_rdata;
          id_pc_d    = req_pc_q;
        end else begin
          id_valid_d = 1'b0;
          id_inst_d  = NOP_INST;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_REQ;
      req_pc_q   <= '0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
    end
  end

  fetch_skid_reg u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (skid_load),
    .i_clear (skid_clear),
    .i_inst  (i_imem_rdata),
    .i_pc    (req_pc_q),
    .o_valid (skid_valid),
    .o_inst  (skid_inst),
    .o_pc    (skid_pc)
  );

  assign o_id_valid  = id_valid_q;
  assign o_id_inst   = id_inst_q;
  assign o_id_pc     = id_pc_q;
  assign o_id_inc_pc = id_pc_q + 32'd4;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_pc;
  logic        i_flush;
  logic        i_id_stall;
  logic        o_if_en;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_id_valid;
  logic [31:0] o_id_inst;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inc_pc;

  if_fetch_unit #(.NOP_INST(NOP)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pc         (i_pc),
    .i_flush      (i_flush),
    .i_id_stall   (i_id_stall),
    .o_if_en      (o_if_en),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ready (i_imem_ready),
    .i_imem_valid (i_imem_valid),
    .i_imem_rdata (i_imem_rdata),
    .o_id_valid   (o_id_valid),
    .o_id_inst    (o_id_inst),
    .o_id_pc      (o_id_pc),
    .o_id_inc_pc  (o_id_inc_pc)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0;
  int errors = 0;

  // Environment models: PC register, cache, and expected in-order stream.
  logic [31:0] pc_reg;
  logic [31:0] flush_target;
  int unsigned lat;
  logic        cache_busy;
  int unsigned cache_cnt;
  logic [31:0] cache_addr;
  logic [31:0] exp_q[$];
  int          consumed;

  // Pre-edge samples of the current cycle.
  logic        s_req, s_if_en, s_id_valid;
  logic [31:0] s_addr, s_id_pc, s_id_inst, s_inc;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    i_pc         = pc_reg;
    i_imem_valid = i_rst_n && cache_busy && (cache_cnt == 0);
    i_imem_rdata = i_imem_valid ? inst_of(cache_addr) : $urandom;
    #1;
    s_req      = o_imem_req;
    s_if_en    = o_if_en;
    s_addr     = o_imem_addr;
    s_id_valid = o_id_valid;
    s_id_pc    = o_id_pc;
    s_id_inst  = o_id_inst;
    s_inc      = o_id_inc_pc;
    if (i_rst_n) begin
      checks++;
      if (s_if_en !== (s_req & i_imem_ready)) begin
        errors++; $display("FAIL if_en got %b want %b", s_if_en, s_req & i_imem_ready);
      end
      if (i_flush) begin
        checks++;
        if (s_req !== 1'b0) begin errors++; $display("FAIL req_on_flush got %b want 0", s_req); end
      end
      if (s_req) begin
        checks++;
        if (s_addr !== i_pc) begin errors++; $display("FAIL addr got %h want %h", s_addr, i_pc); end
      end
      if (s_if_en) begin
        checks++;
        if (cache_busy) begin errors++; $display("FAIL one_outstanding got 2 want 1"); end
      end
      checks++;
      if (exp_q.size() > 2) begin
        errors++; $display("FAIL occupancy got %0d want <=2", exp_q.size());
      end
      if (s_id_valid) begin
        checks++;
        if (exp_q.size() == 0 || s_id_pc !== exp_q[0]) begin
          errors++;
          $display("FAIL id_pc got %h want %h", s_id_pc, exp_q.size() ? exp_q[0] : 32'hx);
        end
        checks++;
        if (s_id_inst !== inst_of(s_id_pc)) begin
          errors++; $display("FAIL id_inst got %h want %h", s_id_inst, inst_of(s_id_pc));
        end
        checks++;
        if (s_inc !== s_id_pc + 32'd4) begin
          errors++; $display("FAIL inc_pc got %h want %h", s_inc, s_id_pc + 32'd4);
        end
      end else begin
        checks++;
        if (s_id_inst !== NOP) begin errors++; $display("FAIL bubble got %h want %h", s_id_inst, NOP); end
      end
    end
    @(posedge i_clk);
    #1;
    if (!i_rst_n) begin
      exp_q.delete();
      cache_busy = 1'b0;
    end else begin
      if (i_imem_valid) cache_busy = 1'b0;
      else if (cache_busy && cache_cnt > 0) cache_cnt--;
      if (s_if_en) begin
        cache_busy = 1'b1;
        cache_addr = s_addr;
        cache_cnt  = lat - 1;
      end
      if (i_flush) begin
        exp_q.delete();
        pc_reg = flush_target;
      end else begin
        if (s_id_valid && !i_id_stall && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          consumed++;
        end
        if (s_if_en) begin
          exp_q.push_back(s_addr);
          pc_reg = pc_reg + 32'd4;
        end
      end
    end
    @(negedge i_clk);
  endtask

  task automatic do_reset(input logic [31:0] start);
    i_rst_n = 1'b0; i_flush = 1'b0; i_id_stall = 1'b0; i_imem_ready = 1'b1; lat = 1;
    exp_q.delete(); cache_busy = 1'b0; pc_reg = start;
    tick(); tick();
    i_rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++; if (o_id_valid !== 1'b0) begin errors++; $display("FAIL %s valid got %b want 0", tag, o_id_valid); end
    checks++; if (o_id_inst !== NOP) begin errors++; $display("FAIL %s inst got %h want %h", tag, o_id_inst, NOP); end
    checks++; if (o_id_pc !== 32'd0) begin errors++; $display("FAIL %s pc got %h want 0", tag, o_id_pc); end
    checks++; if (o_id_inc_pc !== 32'd4) begin errors++; $display("FAIL %s inc got %h want 4", tag, o_id_inc_pc); end
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL %s req got %b want 0", tag, o_imem_req); end
    checks++; if (o_if_en !== 1'b0) begin errors++; $display("FAIL %s if_en got %b want 0", tag, o_if_en); end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_imem_ready = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(negedge i_clk);
  endtask

  task automatic test_zero_wait();
    do_reset(32'd4);
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s_if_en !== ((i % 2) == 0)) begin
        errors++; $display("FAIL zw_if_en cyc %0d got %b want %b", i, s_if_en, (i % 2) == 0);
      end
      checks++;
      if (o_id_valid !== (i % 2 == 1)) begin
        errors++; $display("FAIL zw_valid cyc %0d got %b want %b", i, o_id_valid, i % 2 == 1);
      end
      if (i % 2 == 1) begin
        checks++;
        if (o_id_pc !== 32'(4 + 2 * i - 2)) begin
          errors++; $display("FAIL zw_pc got %h want %h", o_id_pc, 32'(4 + 2 * i - 2));
        end
      end
    end
  endtask

  task automatic test_first_fetch();
    do_reset(32'd4);
    tick(); tick();
    checks++; if (o_id_inst !== inst_of(32'd4)) begin errors++; $display("FAIL ff_inst got %h want %h", o_id_inst, inst_of(32'd4)); end
    checks++; if (o_id_pc !== 32'd4) begin errors++; $display("FAIL ff_pc got %h want 4", o_id_pc); end
    checks++; if (o_id_inc_pc !== 32'd8) begin errors++; $display("FAIL ff_inc got %h want 8", o_id_inc_pc); end
  endtask

  task automatic test_stall_skid();
    do_reset(32'h100);
    tick(); tick();
    i_id_stall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL skid_req_blocked got %b want 0", s_req); end
    checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h100) begin
      errors++; $display("FAIL skid_hold got %b/%h want 1/00000100", o_id_valid, o_id_pc);
    end
    i_id_stall = 1'b0;
    tick();
    checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h104) begin
      errors++; $display("FAIL skid_move got %b/%h want 1/00000104", o_id_valid, o_id_pc);
    end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h108) begin
      errors++; $display("FAIL skid_resume got %b/%h want 1/00000108", s_req, s_addr);
    end
    checks++; if (o_id_valid !== 1'b0) begin errors++; $display("FAIL skid_bubble got %b want 0", o_id_valid); end
    tick();
    checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h108) begin
      errors++; $display("FAIL skid_next got %b/%h want 1/00000108", o_id_valid, o_id_pc);
    end
  endtask

  task automatic test_flush_wait();
    bit seen;
    do_reset(32'h200);
    tick(); tick();
    i_id_stall = 1'b1; lat = 4;
    tick();
    checks++; if (o_id_valid !== 1'b1) begin errors++; $display("FAIL fw_pre got %b want 1", o_id_valid); end
    i_flush = 1'b1; flush_target = 32'h400;
    tick();
    i_flush = 1'b0; i_id_stall = 1'b0; lat = 1;
    checks++; if (o_id_valid !== 1'b0) begin errors++; $display("FAIL fw_clear got %b want 0", o_id_valid); end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = s_req;
      checks++; if (o_id_valid !== 1'b0) begin errors++; $display("FAIL fw_stale got %b/%h want 0", o_id_valid, o_id_inst); end
    end
    checks++; if (!seen) begin errors++; $display("FAIL fw_timeout got no request want request"); end
    checks++; if (s_addr !== 32'h400) begin errors++; $display("FAIL fw_target got %h want 00000400", s_addr); end
    tick();
    checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h400) begin
      errors++; $display("FAIL fw_load got %b/%h want 1/00000400", o_id_valid, o_id_pc);
    end
  endtask

  task automatic test_flush_ready();
    do_reset(32'h300);
    i_flush = 1'b1; flush_target = 32'h800;
    tick();
    checks++; if (s_req !== 1'b0 || s_if_en !== 1'b0) begin
      errors++; $display("FAIL fr_block got %b/%b want 0/0", s_req, s_if_en);
    end
    i_flush = 1'b0;
    tick();
    checks++; if (s_if_en !== 1'b1 || s_addr !== 32'h800) begin
      errors++; $display("FAIL fr_issue got %b/%h want 1/00000800", s_if_en, s_addr);
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset(32'h500);
    tick(); tick();
    i_id_stall = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (s_req !== 1'b0 || o_id_valid !== 1'b1) begin
      errors++; $display("FAIL rh_in_hold got %b/%b want 0/1", s_req, o_id_valid);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_hold");
    @(negedge i_clk);
    exp_q.delete(); cache_busy = 1'b0; pc_reg = 32'h600; i_id_stall = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    checks++; if (s_if_en !== 1'b1 || s_addr !== 32'h600) begin
      errors++; $display("FAIL rh_restart got %b/%h want 1/00000600", s_if_en, s_addr);
    end
    tick();
    checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h600) begin
      errors++; $display("FAIL rh_load got %b/%h want 1/00000600", o_id_valid, o_id_pc);
    end
  endtask

  task automatic test_inc_wrap();
    do_reset(32'hFFFF_FFFC);
    tick(); tick();
    checks++; if (o_id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h want fffffffc", o_id_pc); end
    checks++; if (o_id_inc_pc !== 32'd0) begin errors++; $display("FAIL wrap_inc got %h want 0", o_id_inc_pc); end
  endtask

  task automatic test_random();
    int c0;
    do_reset(32'h1000);
    for (int i = 0; i < 600; i++) begin
      i_id_stall   = ($urandom % 10) < 3;
      i_imem_ready = ($urandom % 10) < 7;
      i_flush      = ($urandom % 20) == 0;
      flush_target = $urandom & 32'hFFFF_FFFC;
      lat          = $urandom_range(1, 4);
      tick();
    end
    i_id_stall = 1'b0; i_imem_ready = 1'b1; i_flush = 1'b0; lat = 1;
    for (int i = 0; i < 6; i++) tick();
    c0 = consumed;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (consumed - c0 < 9) begin
      errors++; $display("FAIL throughput got %0d want >=9 per 20 cycles", consumed - c0);
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_pc = '0; i_flush = 1'b0; i_id_stall = 1'b0;
    i_imem_ready = 1'b1; i_imem_valid = 1'b0; i_imem_rdata = '0;
    pc_reg = '0; flush_target = '0; lat = 1; cache_busy = 1'b0; cache_cnt = 0;
    cache_addr = '0; consumed = 0;
    @(negedge i_clk);
    test_reset();
    test_zero_wait();
    test_first_fetch();
    test_stall_skid();
    test_flush_wait();
    test_flush_ready();
    test_reset_mid_hold();
    test_inc_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

- Sits between the PC register stage and the decode stage.
- Issues one instruction-cache read per PC and returns `o_if_en` to advance the PC.
- Captures the returned instruction into the IF/ID pipeline register, with a one-entry skid buffer so a decode stall never loses a response.
- On a flush it drops any in-flight read and inserts bubbles.

## Interface
- `NOP_INST`, default `32'h0000_0013`: instruction word driven on `o_id_inst` when `o_id_valid` is 0.
- `i_clk`, in, 1: sole clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_pc`, in, 32: current PC from the PC register.
- `i_flush`, in, 1: redirect from a branch or jump; the PC register loads the target on this same edge.
- `i_id_stall`, in, 1: decode cannot accept a new instruction this cycle.
- `o_if_en`, out, 1: PC advance enable, driven to the PC register's enable input.
- `o_imem_req`, out, 1: read request to the instruction cache.
- `o_imem_addr`, out, 32: request address, always equal to `i_pc`.
- `i_imem_ready`, in, 1: cache accepts the request this cycle.
- `i_imem_valid`, in, 1: read data valid, one pulse per accepted request, at least 1 cycle after acceptance.
- `i_imem_rdata`, in, 32: instruction word.
- `o_id_valid`, out, 1: IF/ID register holds a live instruction.
- `o_id_inst`, out, 32: IF/ID instruction.
- `o_id_pc`, out, 32: PC of `o_id_inst`.
- `o_id_inc_pc`, out, 32: `o_id_pc + 4`, modulo 2^32.

## Operation
- **FSM states:** `S_REQ`, `S_WAIT`, `S_HOLD`, `S_DRAIN`. At most one request is outstanding at any time.
- **Combinational outputs:**
  - `o_imem_req = (state==S_REQ) & ~i_flush & i_rst_n`.
  - `o_if_en = o_imem_req & i_imem_ready`.
- **`S_REQ`:**
  - On `o_if_en`, latch `i_pc` into `req_pc` and go to `S_WAIT`.
  - Otherwise stay.
- **`S_WAIT`** (`i_imem_valid` with no flush):
  - If IF/ID can load (`~o_id_valid | ~i_id_stall`), load IF/ID with {`rdata`, `req_pc`} and go to `S_REQ`.
  - Otherwise write the skid buffer and go to `S_HOLD`.
- **`S_HOLD`:** when `~i_id_stall`, move the skid buffer into IF/ID, clear the skid, and go to `S_REQ`.
- **`S_DRAIN`:** wait for the stale response and discard it, then go to `S_REQ`.
- **IF/ID register:**
  - Holds while `o_id_valid & i_id_stall`.
  - When it can load and no instruction is available, it takes a bubble: `valid=0`, `inst=NOP_INST`, pc unchanged.
- **Flush (highest priority):**
  - Clears IF/ID (`valid=0`, `inst=NOP_INST`) and the skid buffer.
  - Next state by current state:
    - `S_REQ` → stay `S_REQ`.
    - `S_HOLD` → `S_REQ`.
    - `S_WAIT` without `i_imem_valid` that cycle → `S_DRAIN`.
    - `S_WAIT` with `i_imem_valid` that cycle → response discarded, `S_REQ`.
    - `S_DRAIN` → stay `S_DRAIN`, or `S_REQ` if `i_imem_valid` arrives.
- **Reset (asynchronous, any state, mid-request included):**
  - State → `S_REQ`.
  - `o_id_valid=0`, `o_id_inst=NOP_INST`, `o_id_pc=0`, `o_id_inc_pc=4`, skid empty, `req_pc=0`.
  - `o_imem_req=0` and `o_if_en=0` while `i_rst_n` is low.
  - A response still owed by the cache after reset is the cache's responsibility to squash.

## Timing
- **Latency:** request accepted at edge N; response at cycle N+k (k≥1); `o_id_valid` high from edge N+k+1.
- **Throughput:** peak is one instruction per 2 cycles (zero-wait cache: ready=1, valid one cycle after accept).
- **PC handshake:** the PC register advances on the same edge the request is accepted. `i_pc` therefore shows the next PC in the cycle after `S_REQ` is left.
- **Request stability:** `o_imem_req` is never asserted in the cycle `i_flush` is high, so a stale address is never accepted on a redirect edge.
- **Stall during the request phase:** a decode stall does not block requests while the skid buffer is empty. A request is blocked only in `S_HOLD`.

## Structure
- **Shared package `fetch_pkg`:**
  - State enum (2-bit) with `S_REQ=0`, `S_WAIT=1`, `S_HOLD=2`, `S_DRAIN=3`.
  - `NOP_INST` constant.
  - `ILEN=32`.
- **One sub-module, `fetch_skid_reg`:**
  - A 64-bit data+pc register with a valid bit.
  - Inputs: load, clear, async active-low reset.
  - Instantiated once for the skid buffer.
- **The IF/ID register** is written inline in the top module.

## Test plan
- **Reset, then zero-wait cache, `i_pc` stepping 4, 8, 12:**
  - `o_id_valid` first rises 2 edges after reset release with `inst=rdata(4)`, `pc=4`, `inc_pc=8`.
  - `o_if_en` pulses every other cycle.
- **Decode stall while a response arrives in `S_WAIT` with IF/ID full:**
  - The response is kept in the skid buffer and no request is issued.
  - After the stall drops, the IF/ID sequence is old instruction, then the skid instruction, in order, with none lost.
- **Flush in `S_WAIT`, response 3 cycles later:**
  - `o_id_valid` is 0 on the next edge.
  - The stale instruction never appears.
  - The next request address is the flush target.
- **`i_flush` and `i_imem_ready` high in the same `S_REQ` cycle:**
  - `o_imem_req=0` and `o_if_en=0`.
  - The request is issued next cycle with the target PC.
- **Assert `i_rst_n` low mid-`S_HOLD`:**
  - Outputs return to their reset values immediately, without waiting for a clock edge.
  - Fetch restarts cleanly in `S_REQ`.
- **`o_id_pc = 32'hFFFF_FFFC`:** `o_id_inc_pc = 0`.
